// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Used by the top-level arbiter and the busy scoreboard.
package rf_arb_pkg;

    localparam int REG_CNT = 32;
    localparam int REG_AW  = 5;

    localparam logic [REG_AW-1:0] RD_ZERO = 5'd0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic        vld;
        wb_src_e     src;
        logic [4:0]  rd;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers with an outstanding load.
// Provides the issue-ready lookup and the decode-stage stall.
module rf_scoreboard
    import rf_arb_pkg::*;
(
    input  logic               clk,
    input  logic               res,
    input  logic               set_valid,
    input  logic [REG_AW-1:0]  set_rd,
    input  logic               clr_en,
    input  logic [REG_AW-1:0]  clr_rd,
    input  logic [REG_AW-1:0]  rs1_addr,
    input  logic [REG_AW-1:0]  rs2_addr,
    input  logic [REG_AW-1:0]  rd_addr,
    output logic               set_ready,
    output logic               stall,
    output logic [REG_CNT-1:0] busy_vec
);

    // x0 has no storage so its busy bit is a hard zero
    logic [REG_CNT-1:1] busy_r;
    logic               clr_hit_s;
    logic               set_fire_s;
    logic [REG_CNT-1:0] set_mask_s;
    logic [REG_CNT-1:0] clr_mask_s;
    logic [REG_CNT-1:0] busy_next_s;

    assign busy_vec = {busy_r, 1'b0};
    assign stall    = busy_vec[rs1_addr] | busy_vec[rs2_addr] | busy_vec[rd_addr];

    // Issue lookup; refuse a register whose clear is landing this cycle
    always_comb begin
        clr_hit_s = clr_en & (clr_rd == set_rd);
        if (res) begin
            set_ready = 1'b0;
        end else if (set_rd == RD_ZERO) begin
            set_ready = 1'b1;
        end else begin
            set_ready = ~busy_vec[set_rd] & ~clr_hit_s;
        end
        set_fire_s = set_valid & set_ready & (set_rd != RD_ZERO);
    end

    // Next busy vector: clear applied first, then set, so set wins
    always_comb begin
        set_mask_s  = set_fire_s ? (32'd1 << set_rd) : 32'd0;
        clr_mask_s  = clr_en     ? (32'd1 << clr_rd) : 32'd0;
        busy_next_s = (busy_vec & ~clr_mask_s) | set_mask_s;
    end

    // Busy state register
    always_ff @(posedge clk) begin
        if (res) begin
            busy_r <= {(REG_CNT-1){1'b0}};
        end else begin
            busy_r <= busy_next_s[REG_CNT-1:1];
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU writeback and load return,
// with starvation protection for loads and a registered write stage.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 3
)
(
    input  logic               clk,
    input  logic               res,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [4:0]         alu_rd,
    input  logic [XLEN-1:0]    alu_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [4:0]         ld_rd,
    input  logic [XLEN-1:0]    ld_data,
    input  logic               ld_issue_valid,
    input  logic [4:0]         ld_issue_rd,
    output logic               ld_issue_ready,
    input  logic [4:0]         dec_rs1_addr,
    input  logic [4:0]         dec_rs2_addr,
    input  logic [4:0]         dec_rd_addr,
    output logic               dec_stall,
    output logic               rf_wr_en,
    output logic [4:0]         rf_rd_addr,
    output logic [XLEN-1:0]    rf_wr_data,
    output logic [31:0]        busy_vec
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    logic             alu_req_s;
    logic             ld_req_s;
    logic             force_s;
    logic             alu_grant_s;
    logic             ld_grant_s;
    logic [CNT_W-1:0] starve_r;
    logic [CNT_W-1:0] starve_next_s;
    wb_req_t          wb_r;
    wb_req_t          wb_next_s;
    logic [XLEN-1:0]  data_r;
    logic [XLEN-1:0]  data_next_s;
    logic             clr_en_s;

    // Arbitration: ALU has priority unless the load has lost STARVE_MAX times in a row
    always_comb begin
        alu_req_s = alu_valid & (alu_rd != RD_ZERO);
        ld_req_s  = ld_valid & (ld_rd != RD_ZERO);
        force_s   = ld_req_s & (starve_r == STARVE_LIM);
        if (res) begin
            alu_ready = 1'b0;
            ld_ready  = 1'b0;
        end else begin
            alu_ready = (alu_rd == RD_ZERO) | ~force_s;
            ld_ready  = (ld_rd == RD_ZERO) | ~alu_req_s | force_s;
        end
        alu_grant_s = alu_req_s & alu_ready;
        ld_grant_s  = ld_req_s & ld_ready;
    end

    // Starvation counter: saturating count of consecutive lost load arbitrations
    always_comb begin
        starve_next_s = starve_r;
        if (~ld_req_s | ld_grant_s) begin
            starve_next_s = CNT_ZERO;
        end else if (starve_r != STARVE_LIM) begin
            starve_next_s = starve_r + CNT_ONE;
        end else begin
            starve_next_s = starve_r;
        end
    end

    // Next write-stage contents; address and data hold when nothing is granted
    always_comb begin
        wb_next_s.vld = 1'b0;
        wb_next_s.src = wb_r.src;
        wb_next_s.rd  = wb_r.rd;
        data_next_s   = data_r;
        if (alu_grant_s) begin
            wb_next_s.vld = 1'b1;
            wb_next_s.src = SRC_ALU;
            wb_next_s.rd  = alu_rd;
            data_next_s   = alu_data;
        end else if (ld_grant_s) begin
            wb_next_s.vld = 1'b1;
            wb_next_s.src = SRC_LD;
            wb_next_s.rd  = ld_rd;
            data_next_s   = ld_data;
        end else begin
            wb_next_s.vld = 1'b0;
        end
    end

    // Write stage and starvation counter registers
    always_ff @(posedge clk) begin
        if (res) begin
            wb_r.vld <= 1'b0;
            wb_r.src <= SRC_ALU;
            wb_r.rd  <= RD_ZERO;
            data_r   <= {XLEN{1'b0}};
            starve_r <= CNT_ZERO;
        end else begin
            wb_r     <= wb_next_s;
            data_r   <= data_next_s;
            starve_r <= starve_next_s;
        end
    end

    assign rf_wr_en   = wb_r.vld;
    assign rf_rd_addr = wb_r.rd;
    assign rf_wr_data = data_r;

    // A load-sourced write retires its busy bit on the same edge the RF is written
    assign clr_en_s = wb_r.vld & (wb_r.src == SRC_LD);

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .res       (res),
        .set_valid (ld_issue_valid),
        .set_rd    (ld_issue_rd),
        .clr_en    (clr_en_s),
        .clr_rd    (wb_r.rd),
        .rs1_addr  (dec_rs1_addr),
        .rs2_addr  (dec_rs2_addr),
        .rd_addr   (dec_rd_addr),
        .set_ready (ld_issue_ready),
        .stall     (dec_stall),
        .busy_vec  (busy_vec)
    );

endmodule
